// File: rtl/athena_hiscore_ctrl.sv
// Athena hiscore controller: restores a saved hiscore table into side RAM
// and dumps the side RAM table back to the hiscore buffer on request.

package athena;

   typedef struct packed {
      logic [10:0] addr;
      logic [7:0]  data_in;
      logic        nCS;
      logic        nWE;
   } side_ram_t;

endpackage

module athena_hiscore_ctrl
   import athena::*;
#(
   parameter logic [10:0] HS_BASE = 11'h650,
   parameter int          HS_LEN  = 114
) (
   input  logic       game_clk,
   input  logic       reset_n,
   input  side_ram_t  game_ram_req,
   output side_ram_t  side_ram_out,
   input  logic [7:0] ram_rdata,
   input  logic       base_written,
   input  logic       load_valid,
   input  logic       dump_req,
   output logic [6:0] buf_addr,
   output logic [7:0] buf_wdata,
   output logic       buf_we,
   input  logic [7:0] buf_rdata,
   output logic       busy,
   output logic       load_done,
   output logic       dump_done
);

   typedef enum logic [2:0] {
      WAIT_BASE,
      IDLE,
      LOAD_RD,
      LOAD_WR,
      DUMP_RD,
      DUMP_WR
   } state_t;

   localparam logic [6:0] LAST = 7'(HS_LEN - 1);

   state_t      state;
   logic [6:0]  idx;
   logic        dump_pending;
   logic        game_idle;
   logic        is_last;
   logic        issue_wr;
   logic        issue_rd;
   logic [10:0] hs_addr;

   assign game_idle = game_ram_req.nCS;
   assign is_last   = (idx == LAST);
   assign hs_addr   = HS_BASE + {4'b0000, idx};
   assign issue_wr  = (state == LOAD_WR) && game_idle;
   assign issue_rd  = (state == DUMP_RD) && game_idle;

   // Buffer side: address tracks idx, write only in the DUMP_WR cycle
   // while the side-RAM read data is valid.
   assign buf_addr  = idx;
   assign buf_we    = (state == DUMP_WR);
   assign buf_wdata = buf_we ? ram_rdata : 8'h00;

   // Side-RAM mux: the game owns the bus unless it is idle and we need it.
   always_comb begin
      side_ram_out = game_ram_req;
      if (issue_wr) begin
         side_ram_out.addr    = hs_addr;
         side_ram_out.data_in = buf_rdata;
         side_ram_out.nCS     = 1'b0;
         side_ram_out.nWE     = 1'b0;
      end else if (issue_rd) begin
         side_ram_out.addr    = hs_addr;
         side_ram_out.data_in = 8'h00;
         side_ram_out.nCS     = 1'b0;
         side_ram_out.nWE     = 1'b1;
      end
   end

   // Copy sequencer with registered busy/done outputs and dump pending flag.
   always_ff @(posedge game_clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= WAIT_BASE;
         idx          <= 7'd0;
         dump_pending <= 1'b0;
         busy         <= 1'b0;
         load_done    <= 1'b0;
         dump_done    <= 1'b0;
      end else begin
         load_done <= 1'b0;
         dump_done <= 1'b0;
         if (dump_req && (state != IDLE))
            dump_pending <= 1'b1;
         unique case (state)
            WAIT_BASE: begin
               if (base_written) begin
                  idx <= 7'd0;
                  if (load_valid) begin
                     state <= LOAD_RD;
                     busy  <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            IDLE: begin
               if (dump_req || dump_pending) begin
                  state        <= DUMP_RD;
                  idx          <= 7'd0;
                  dump_pending <= 1'b0;
                  busy         <= 1'b1;
               end
            end
            LOAD_RD: begin
               state <= LOAD_WR;
            end
            LOAD_WR: begin
               if (game_idle) begin
                  if (is_last) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     idx   <= idx + 7'd1;
                     state <= LOAD_RD;
                  end
               end
            end
            DUMP_RD: begin
               if (game_idle)
                  state <= DUMP_WR;
            end
            DUMP_WR: begin
               if (is_last) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  dump_done <= 1'b1;
               end else begin
                  idx   <= idx + 7'd1;
                  state <= DUMP_RD;
               end
            end
            default: begin
               state <= WAIT_BASE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_athena_hiscore_ctrl.sv
// Bench for athena_hiscore_ctrl: RAM/buffer models, write scoreboards,
// vector table for reset/arbitration, and load/dump/reset sequences.

module tb_athena_hiscore_ctrl;
   import athena::*;

   localparam int HS_LEN = 114;
   localparam side_ram_t IDLE_REQ = '{11'h000, 8'h00, 1'b1, 1'b1};

   logic       game_clk = 1'b0;
   logic       reset_n;
   side_ram_t  game_ram_req;
   side_ram_t  side_ram_out;
   logic [7:0] ram_rdata;
   logic       base_written;
   logic       load_valid;
   logic       dump_req;
   logic [6:0] buf_addr;
   logic [7:0] buf_wdata;
   logic       buf_we;
   logic [7:0] buf_rdata;
   logic       busy;
   logic       load_done;
   logic       dump_done;

   always #5 game_clk = ~game_clk;

   athena_hiscore_ctrl dut (
      .game_clk     (game_clk),
      .reset_n      (reset_n),
      .game_ram_req (game_ram_req),
      .side_ram_out (side_ram_out),
      .ram_rdata    (ram_rdata),
      .base_written (base_written),
      .load_valid   (load_valid),
      .dump_req     (dump_req),
      .buf_addr     (buf_addr),
      .buf_wdata    (buf_wdata),
      .buf_we       (buf_we),
      .buf_rdata    (buf_rdata),
      .busy         (busy),
      .load_done    (load_done),
      .dump_done    (dump_done)
   );

   function automatic logic [7:0] ram_pat(input int i);
      if (i == 0) return 8'heb;
      if (i == HS_LEN - 1) return 8'hff;
      return 8'(i * 13 + 5);
   endfunction

   function automatic logic [7:0] buf_pat(input int i);
      return 8'(i * 29 + 8'h41) ^ 8'h5a;
   endfunction

   // Side RAM and hiscore buffer models
   logic [7:0] mem  [0:2047];
   logic [7:0] bufm [0:127];
   logic       fill_ram = 1'b0;
   logic       fill_buf = 1'b0;
   logic [7:0] fill_x = 8'h00;

   always @(posedge game_clk) begin
      if (fill_ram)
         for (int i = 0; i < HS_LEN; i++)
            mem[11'h650 + i] <= ram_pat(i) ^ fill_x;
      if (fill_buf)
         for (int i = 0; i < HS_LEN; i++)
            bufm[i] <= buf_pat(i) ^ fill_x;
      if (!side_ram_out.nCS) begin
         if (!side_ram_out.nWE)
            mem[side_ram_out.addr] <= side_ram_out.data_in;
         else
            ram_rdata <= mem[side_ram_out.addr];
      end
      buf_rdata <= bufm[buf_addr];
      if (buf_we)
         bufm[buf_addr] <= buf_wdata;
   end

   typedef struct packed {
      logic [10:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t ram_q[$];
   wr_t buf_q[$];
   int  errors = 0;
   int  checks = 0;
   int  n_load_done = 0;
   int  n_dump_done = 0;
   int  cyc = 0;
   logic traffic_en = 1'b0;
   int  tk = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge game_clk) cyc <= cyc + 1;

   // Monitor: arbitration, RAM write scoreboard, buffer write scoreboard
   always @(negedge game_clk) begin
      wr_t e;
      if (load_done) n_load_done++;
      if (dump_done) n_dump_done++;
      if (game_ram_req.nCS == 1'b0) begin
         chk("arb_game_wins", 32'(side_ram_out), 32'(game_ram_req));
      end else if (side_ram_out.nCS == 1'b1) begin
         chk("arb_pass_idle", 32'(side_ram_out), 32'(game_ram_req));
      end else if (side_ram_out.nWE == 1'b0) begin
         if (ram_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ram_wr: got addr %h data %h, none required",
                     side_ram_out.addr, side_ram_out.data_in);
         end else begin
            e = ram_q.pop_front();
            chk("ram_wr", {13'd0, side_ram_out.addr, side_ram_out.data_in},
                {13'd0, e.a, e.d});
         end
      end
      if (buf_we) begin
         if (buf_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_buf_wr: got addr %h data %h, none required",
                     buf_addr, buf_wdata);
         end else begin
            e = buf_q.pop_front();
            chk("buf_wr", {13'd0, 4'd0, buf_addr, buf_wdata}, {13'd0, e.a, e.d});
         end
      end
   end

   // Background game traffic: access every other cycle outside the table
   always @(posedge game_clk) begin
      #1;
      if (traffic_en) begin
         tk = tk + 1;
         if (tk[0])
            game_ram_req = '{11'h100 + {3'd0, tk[7:0]}, tk[7:0], 1'b0, tk[1]};
         else
            game_ram_req = IDLE_REQ;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge game_clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n      = 1'b0;
      base_written = 1'b0;
      load_valid   = 1'b0;
      dump_req     = 1'b0;
      game_ram_req = IDLE_REQ;
      tick(3);
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic do_fill(input logic ram, input logic [7:0] x);
      fill_x = x;
      if (ram) fill_ram = 1'b1;
      else fill_buf = 1'b1;
      tick(1);
      fill_ram = 1'b0;
      fill_buf = 1'b0;
   endtask

   typedef struct {
      logic      rst_n;
      side_ram_t req;
      logic      bw;
      logic      lv;
      side_ram_t exp_side;
      logic      exp_busy;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int t0;
      int t1;
      logic hit;

      vecs[0] = '{1'b0, '{11'h650, 8'h12, 1'b0, 1'b0}, 1'b1, 1'b1,
                  '{11'h650, 8'h12, 1'b0, 1'b0}, 1'b0};
      vecs[1] = '{1'b0, '{11'h6c1, 8'h00, 1'b0, 1'b1}, 1'b1, 1'b0,
                  '{11'h6c1, 8'h00, 1'b0, 1'b1}, 1'b0};
      vecs[2] = '{1'b1, '{11'h000, 8'h00, 1'b1, 1'b1}, 1'b0, 1'b1,
                  '{11'h000, 8'h00, 1'b1, 1'b1}, 1'b0};
      vecs[3] = '{1'b1, '{11'h7ff, 8'haa, 1'b0, 1'b0}, 1'b0, 1'b1,
                  '{11'h7ff, 8'haa, 1'b0, 1'b0}, 1'b0};
      vecs[4] = '{1'b1, '{11'h123, 8'h55, 1'b1, 1'b0}, 1'b0, 1'b0,
                  '{11'h123, 8'h55, 1'b1, 1'b0}, 1'b0};
      vecs[5] = '{1'b1, '{11'h000, 8'h00, 1'b1, 1'b1}, 1'b1, 1'b0,
                  '{11'h000, 8'h00, 1'b1, 1'b1}, 1'b0};

      // Phase A: reset values and pass-through in WAIT_BASE, then IDLE w/o load
      do_reset();
      foreach (vecs[i]) begin
         reset_n      = vecs[i].rst_n;
         game_ram_req = vecs[i].req;
         base_written = vecs[i].bw;
         load_valid   = vecs[i].lv;
         @(negedge game_clk);
         chk($sformatf("vec%0d_side", i), 32'(side_ram_out), 32'(vecs[i].exp_side));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         chk($sformatf("vec%0d_out0", i),
             {load_done, dump_done, buf_we, buf_addr, buf_wdata}, 32'd0);
         tick(1);
      end
      game_ram_req = IDLE_REQ;
      tick(30);
      load_valid = 1'b1;
      tick(5);
      @(negedge game_clk);
      chk("noload_busy", 32'(busy), 32'd0);
      chk("noload_done", n_load_done, 0);
      chk("noload_wr_q", ram_q.size(), 0);
      tick(1);

      // Phase B: dump from IDLE
      do_fill(1'b1, 8'h00);
      for (int i = 0; i < HS_LEN; i++) buf_q.push_back('{11'(i), ram_pat(i)});
      n_dump_done = 0;
      dump_req = 1'b1;
      tick(1);
      dump_req = 1'b0;
      for (int i = 0; i < 600 && n_dump_done == 0; i++) @(negedge game_clk);
      tick(3);
      chk("dump_done_cnt", n_dump_done, 1);
      chk("dump_buf_q", buf_q.size(), 0);
      chk("dump_buf0", 32'(bufm[0]), 32'h eb);
      chk("dump_buf113", 32'(bufm[113]), 32'h ff);
      chk("dump_busy", 32'(busy), 32'd0);

      // Phase C: reset in the middle of a dump at idx 50
      do_fill(1'b1, 8'h3c);
      for (int i = 0; i < HS_LEN; i++) buf_q.push_back('{11'(i), ram_pat(i) ^ 8'h3c});
      dump_req = 1'b1;
      tick(1);
      dump_req = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge game_clk);
         #1;
         if (buf_we && buf_addr == 7'd50) begin
            hit = 1'b1;
            break;
         end
      end
      chk("reach_idx50", 32'(hit), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_buf_we", 32'(buf_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_side_idle", 32'(side_ram_out), 32'(game_ram_req));
      game_ram_req = '{11'h200, 8'ha5, 1'b0, 1'b0};
      #1;
      chk("rst_side_wr", 32'(side_ram_out), 32'(IDLE_REQ) ^ 32'(IDLE_REQ) |
          32'({11'h200, 8'ha5, 1'b0, 1'b0}));
      buf_q.delete();
      tick(3);
      chk("rst_buf50_kept", 32'(bufm[50]), 32'(ram_pat(50)));
      chk("rst_buf49_new", 32'(bufm[49]), 32'(ram_pat(49) ^ 8'h3c));
      chk("rst_addr0", 32'(buf_addr), 32'd0);

      // Phase D: full load with game idle, latency to load_done
      do_reset();
      do_fill(1'b0, 8'h00);
      for (int i = 0; i < HS_LEN; i++)
         ram_q.push_back('{11'h650 + 11'(i), buf_pat(i)});
      n_load_done = 0;
      base_written = 1'b1;
      load_valid   = 1'b1;
      t0 = -1;
      t1 = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge game_clk);
         if (busy) begin
            t0 = cyc;
            break;
         end
      end
      for (int i = 0; i < 500; i++) begin
         @(negedge game_clk);
         if (load_done) begin
            t1 = cyc;
            break;
         end
      end
      chk("load_latency", 32'(t1 - t0), 32'd228);
      tick(5);
      chk("load_done_cnt", n_load_done, 1);
      chk("load_ram_q", ram_q.size(), 0);
      chk("load_mem650", 32'(mem[11'h650]), 32'(buf_pat(0)));
      chk("load_mem6c1", 32'(mem[11'h6c1]), 32'(buf_pat(113)));

      // Phase E: load under game traffic, two dump pulses collapse to one
      do_reset();
      do_fill(1'b0, 8'hc3);
      for (int i = 0; i < HS_LEN; i++)
         ram_q.push_back('{11'h650 + 11'(i), buf_pat(i) ^ 8'hc3});
      n_load_done  = 0;
      n_dump_done  = 0;
      traffic_en   = 1'b1;
      base_written = 1'b1;
      load_valid   = 1'b1;
      for (int i = 0; i < 1000 && n_load_done == 0; i++) begin
         @(negedge game_clk);
         if (i == 20 || i == 60) begin
            dump_req = 1'b1;
            if (i == 20)
               for (int j = 0; j < HS_LEN; j++)
                  buf_q.push_back('{11'(j), buf_pat(j) ^ 8'hc3});
         end else begin
            dump_req = 1'b0;
         end
      end
      dump_req = 1'b0;
      for (int i = 0; i < 1000 && n_dump_done == 0; i++) @(negedge game_clk);
      tick(300);
      traffic_en   = 1'b0;
      game_ram_req = IDLE_REQ;
      tick(2);
      chk("traf_load_done", n_load_done, 1);
      chk("traf_dump_done", n_dump_done, 1);
      chk("traf_ram_q", ram_q.size(), 0);
      chk("traf_buf_q", buf_q.size(), 0);
      chk("traf_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/athena_hiscore_ctrl.md
ATHENA_HISCORE_CTRL -- requirements
Module: athena_hiscore_ctrl

Interface
REQ-001 Parameter HS_BASE, default 11'h650, side-RAM address of first hiscore byte.
REQ-002 Parameter HS_LEN, default 114, hiscore table length in bytes (covers 11'h650..11'h6c1).
REQ-003 game_clk  input  1  sole clock, all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 game_ram_req  input  athena::side_ram_t  game CPU side-RAM request (addr, data_in, nCS, nWE).
REQ-006 side_ram_out  output  athena::side_ram_t  arbitrated request driven to the side RAM.
REQ-007 ram_rdata  input  8  side-RAM read data, valid one cycle after a read is issued.
REQ-008 base_written  input  1  level, high once the game has written its default hiscore table.
REQ-009 load_valid  input  1  level, high when the hiscore buffer holds saved data to restore.
REQ-010 dump_req  input  1  single-cycle pulse requesting copy of side RAM table into the buffer.
REQ-011 buf_addr  output  7  hiscore buffer address (0..HS_LEN-1).
REQ-012 buf_wdata  output  8  hiscore buffer write data.
REQ-013 buf_we  output  1  hiscore buffer write enable.
REQ-014 buf_rdata  input  8  hiscore buffer read data, one-cycle latency from buf_addr.
REQ-015 busy  output  1  high in any LOAD_* or DUMP_* state.
REQ-016 load_done / dump_done  output  1 each  single-cycle completion pulses.

Function
REQ-017 States: WAIT_BASE, IDLE, LOAD_RD, LOAD_WR, DUMP_RD, DUMP_WR; 7-bit index idx.
REQ-018 WAIT_BASE: base_written=1 and load_valid=1 -> LOAD_RD, idx=0; base_written=1 and load_valid=0 -> IDLE; else hold.
REQ-019 LOAD_RD: buf_addr=idx; unconditionally -> LOAD_WR next cycle.
REQ-020 LOAD_WR: when game_ram_req.nCS=1, drive write addr=HS_BASE+idx, data_in=buf_rdata, nCS=0, nWE=0; else hold buf_addr and stay (stall).
REQ-021 After issued LOAD_WR write: idx<HS_LEN-1 -> idx+1, LOAD_RD; idx=HS_LEN-1 -> pulse load_done, IDLE.
REQ-022 IDLE: dump_req or dump_pending -> DUMP_RD, idx=0, clear dump_pending.
REQ-023 DUMP_RD: when game_ram_req.nCS=1, drive read addr=HS_BASE+idx, nCS=0, nWE=1, -> DUMP_WR; else stall in DUMP_RD.
REQ-024 DUMP_WR: buf_addr=idx, buf_wdata=ram_rdata, buf_we=1 for exactly one cycle; idx<HS_LEN-1 -> idx+1, DUMP_RD; else pulse dump_done, IDLE.
REQ-025 Arbitration: game always wins; side_ram_out = game_ram_req in every cycle except when controller issues per REQ-020/REQ-023, which only occurs with game nCS=1.
REQ-026 dump_req arriving outside IDLE sets dump_pending; multiple pulses collapse to one; dump_req in WAIT_BASE is pended, not dropped.
REQ-027 dump_req coincident with IDLE entry from load is serviced immediately after load_done.
REQ-028 base_written/load_valid ignored outside WAIT_BASE; WAIT_BASE re-entered only by reset.
REQ-029 Address sum HS_BASE+idx computed at 11 bits, upper addr bits zero.
REQ-030 buf_we=0 in every state other than DUMP_WR.

Reset
REQ-031 reset_n=0 asynchronously: state=WAIT_BASE, idx=0, dump_pending=0, busy=0, load_done=0, dump_done=0, buf_we=0, buf_addr=0, buf_wdata=0.
REQ-032 During and after reset side_ram_out = game_ram_req; reset mid-copy abandons copy with no further RAM or buffer writes.

Verification
REQ-033 base_written=1, load_valid=1, game idle -> 114 writes at 11'h650..11'h6c1 with buffer bytes, load_done pulse 228 cycles after start.
REQ-034 base_written=1, load_valid=0 -> IDLE, no RAM write, no load_done.
REQ-035 Load with game nCS=0 every other cycle -> no game access altered, all 114 bytes still written in order, load_done once.
REQ-036 dump_req in IDLE, RAM preloaded 8'heb at 11'h650, 8'hff at 11'h6c1 -> buffer addr 0=8'heb, 113=8'hff, dump_done pulse.
REQ-037 dump_req pulsed twice during load -> exactly one dump after load_done.
REQ-038 reset_n low at idx=50 of dump -> buf_we low immediately, state WAIT_BASE, side_ram_out equals game_ram_req.
